// File: rtl/sprite_renderer.sv
// Sprite renderer: each frame erases the previous sprite rectangle with the
// background colour, then draws the new sprite from the sprite ROM. Transparent
// ROM pixels are skipped and off-screen pixels are clipped.
//
// Pixel handshake: a pixel transfers on a rising edge where pixelWrite &&
// pixelReady. While pixelWrite is high and pixelReady is low, xPixel, yPixel
// and pixelData hold stable. pixelWrite never drops without a transfer. When
// pixelWrite is low, xPixel, yPixel and pixelData read as zero.
module sprite_renderer #(
  parameter int          SPRITE_W    = 32,
  parameter int          SPRITE_H    = 32,
  parameter int          SCREEN_W    = 240,
  parameter int          SCREEN_H    = 320,
  parameter logic [15:0] BG_COLOUR   = 16'hFFFF,
  parameter logic [15:0] TRANSPARENT = 16'hF81F,
  localparam int         CW          = $clog2(SPRITE_W),
  localparam int         RW          = $clog2(SPRITE_H)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               update,
  input  logic [7:0]         xSprite,
  input  logic [8:0]         ySprite,
  input  logic [3:0]         spriteId,
  output logic [3+RW+CW:0]   romAddress,
  input  logic [15:0]        romData,
  output logic [7:0]         xPixel,
  output logic [8:0]         yPixel,
  output logic [15:0]        pixelData,
  output logic               pixelWrite,
  input  logic               pixelReady,
  output logic               busy,
  output logic [2:0]         fsmState
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ERASE      = 3'd1,
    DRAW_ADDR  = 3'd2,
    DRAW_DATA  = 3'd3,
    DRAW_WRITE = 3'd4
  } state_t;

  localparam logic [8:0]    SCR_W   = 9'(SCREEN_W);
  localparam logic [9:0]    SCR_H   = 10'(SCREEN_H);
  localparam logic [CW-1:0] COL_ONE = CW'(1);
  localparam logic [RW-1:0] ROW_ONE = RW'(1);

  state_t        state, nextState;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [7:0]    oldX, newX, baseX;
  logic [8:0]    oldY, newY, baseY;
  logic [3:0]    newId;
  logic          hasDrawn, pending;
  logic [15:0]   pixReg;
  logic [8:0]    cx;
  logic [9:0]    cy;
  logic          onScreen, lastPix, advance, startFrame, frameDone;

  // Coordinates are widened by one bit so a sprite hanging off the right or
  // bottom edge is detected rather than wrapping onto the screen.
  assign baseX    = (state == ERASE) ? oldX : newX;
  assign baseY    = (state == ERASE) ? oldY : newY;
  assign cx       = {1'b0, baseX} + 9'(col);
  assign cy       = {1'b0, baseY} + 10'(row);
  assign onScreen = (cx < SCR_W) && (cy < SCR_H);
  assign lastPix  = (&col) && (&row);

  assign romAddress = {newId, row, col};
  assign fsmState   = state;
  assign xPixel     = pixelWrite ? cx[7:0] : 8'd0;
  assign yPixel     = pixelWrite ? cy[8:0] : 9'd0;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic plus the write request and colour for the current pixel.
  always_comb begin
    nextState  = state;
    advance    = 1'b0;
    startFrame = 1'b0;
    frameDone  = 1'b0;
    pixelWrite = 1'b0;
    pixelData  = 16'd0;
    case (state)
      IDLE: begin
        if (update || pending) begin
          startFrame = 1'b1;
          nextState  = hasDrawn ? ERASE : DRAW_ADDR;
        end
      end
      ERASE: begin
        pixelWrite = onScreen;
        pixelData  = onScreen ? BG_COLOUR : 16'd0;
        if (!onScreen || pixelReady) begin
          advance = 1'b1;
          if (lastPix) nextState = DRAW_ADDR;
        end
      end
      DRAW_ADDR: nextState = DRAW_DATA;
      DRAW_DATA: begin
        if (romData == TRANSPARENT || !onScreen) begin
          advance   = 1'b1;
          frameDone = lastPix;
          nextState = lastPix ? IDLE : DRAW_ADDR;
        end else begin
          nextState = DRAW_WRITE;
        end
      end
      DRAW_WRITE: begin
        pixelWrite = 1'b1;
        pixelData  = pixReg;
        if (pixelReady) begin
          advance   = 1'b1;
          frameDone = lastPix;
          nextState = lastPix ? IDLE : DRAW_ADDR;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Frame bookkeeping, scan counters and the registered ROM pixel.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      col      <= '0;
      row      <= '0;
      oldX     <= '0;
      oldY     <= '0;
      newX     <= '0;
      newY     <= '0;
      newId    <= '0;
      hasDrawn <= 1'b0;
      pending  <= 1'b0;
      busy     <= 1'b0;
      pixReg   <= '0;
    end else begin
      if (update && state != IDLE) pending <= 1'b1;
      if (startFrame) begin
        newX    <= xSprite;
        newY    <= ySprite;
        newId   <= spriteId;
        busy    <= 1'b1;
        pending <= 1'b0;
        col     <= '0;
        row     <= '0;
      end
      if (advance) begin
        col <= col + COL_ONE;
        if (&col) row <= row + ROW_ONE;
      end
      if (state == DRAW_DATA) pixReg <= romData;
      if (frameDone) begin
        oldX     <= newX;
        oldY     <= newY;
        hasDrawn <= 1'b1;
        busy     <= 1'b0;
      end
    end
  end

endmodule
